mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: data RAM plus the EX/MEM -> MEM/WB pipeline register.
// Optional MEM_SUBWORD_EN adds byte/half stores and sign/zero-extended sub-word loads.
module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_EX,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  reg_EX,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  wb,
  output logic [31:0] read_data,
  output logic [31:0] address_WB,
  output logic [4:0]  reg_WB,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word;
  logic              lane_misaligned;
  logic              misaligned;
  logic              store_en;
  logic [3:0]        byte_en;
  logic [31:0]       store_word;
  logic [31:0]       load_word;

  assign word_idx = alu_result[ADDR_W+1:2];
  assign cur_word = mem[word_idx];

`ifdef MEM_SUBWORD_EN
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    lane_misaligned = (alu_result[1:0] != 2'b00);
    byte_en         = 4'b1111;
    store_word      = write_data;
    load_word       = cur_word;
    half_lane       = alu_result[1] ? cur_word[31:16] : cur_word[15:0];
    byte_lane       = cur_word[8*alu_result[1:0] +: 8];
    case (size)
      2'b01: begin
        lane_misaligned = alu_result[0];
        byte_en         = alu_result[1] ? 4'b1100 : 4'b0011;
        store_word      = {2{write_data[15:0]}};
        load_word       = {{16{~load_unsigned & half_lane[15]}}, half_lane};
      end
      2'b10: begin
        lane_misaligned = 1'b0;
        byte_en         = 4'b0001 << alu_result[1:0];
        store_word      = {4{write_data[7:0]}};
        load_word       = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
      end
      default: ;
    endcase
  end
`else
  // Sub-word controls are accepted on the port but have no effect in this build.
  logic unused_cfg;
  assign unused_cfg      = ^{size, load_unsigned};
  assign lane_misaligned = (alu_result[1:0] != 2'b00);
  assign byte_en         = 4'b1111;
  assign store_word      = write_data;
  assign load_word       = cur_word;
`endif

  assign misaligned = (mem_read | mem_write) & lane_misaligned;
  assign store_en   = mem_write & ~stall & ~flush & ~rst & ~misaligned;

  // Memory is deliberately not reset; only the pipeline register is.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb         <= 2'b00;
      read_data  <= 32'd0;
      address_WB <= 32'd0;
      reg_WB     <= 5'd0;
      misalign   <= 1'b0;
    end else if (!stall) begin
      wb         <= (flush | misaligned) ? 2'b00 : wb_EX;
      // A load+store pair is a store: report the raw pre-write word.
      read_data  <= (mem_read & ~mem_write) ? load_word : cur_word;
      address_WB <= alu_result;
      reg_WB     <= reg_EX;
      misalign   <= misaligned & ~flush;
    end
  end

endmodule
